// File: rtl/dcache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_flush_ctrl
//
// Whole-cache flush sequencer for the write-back data cache. When a flush is
// requested, it waits for the miss unit to drain. It then walks every
// (set, way) of the metadata array, with way as the inner loop. For each line
// it reads the metadata, writes back dirty lines through the miss/writeback
// unit, and clears the dirty bit. When InvalidateOnFlush is set, it also
// clears the valid bit.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   flush_i            level flush request; flush_ack_o pulses one cycle at end
//   busy_o             high whenever the sequencer is not idle
//   miss_idle_i        miss unit has no outstanding transaction
//   tag_req_o/gnt_i    metadata read handshake for tag_set_o/tag_way_o
//   rd_valid_i/dirty_i metadata returned the cycle after a read grant
//   wb_req_o/gnt_i     writeback request handshake for the current line
//   wb_done_i          writeback finished pulse
//   upd_we_o           metadata write strobe with upd_valid_o/upd_dirty_o
//   wb_count_o         saturating count of writebacks in the last/current flush
// ---------------------------------------------------------------------------
module dcache_flush_ctrl #(
   parameter int unsigned NumSets           = 256,
   parameter int unsigned NumWays           = 8,
   parameter bit          InvalidateOnFlush = 1'b1,
   parameter int unsigned CntW              = 16,
   localparam int unsigned SetW = (NumSets > 1) ? $clog2(NumSets) : 1,
   localparam int unsigned WayW = (NumWays > 1) ? $clog2(NumWays) : 1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   output logic            flush_ack_o,
   output logic            busy_o,
   input  logic            miss_idle_i,
   output logic            tag_req_o,
   input  logic            tag_gnt_i,
   output logic [SetW-1:0] tag_set_o,
   output logic [WayW-1:0] tag_way_o,
   input  logic            rd_valid_i,
   input  logic            rd_dirty_i,
   output logic            wb_req_o,
   input  logic            wb_gnt_i,
   input  logic            wb_done_i,
   output logic            upd_we_o,
   output logic            upd_valid_o,
   output logic            upd_dirty_o,
   output logic [CntW-1:0] wb_count_o
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_WAIT_IDLE,
      S_READ,
      S_CHECK,
      S_WB_REQ,
      S_WB_WAIT,
      S_UPDATE,
      S_NEXT,
      S_DONE
   } state_e;

   state_e          r_state;
   state_e          w_state_nxt;
   logic [SetW-1:0] r_set;
   logic [WayW-1:0] r_way;
   logic [CntW-1:0] r_wb_cnt;
   logic            w_last_set;
   logic            w_last_way;

   assign w_last_set = (r_set == SetW'(NumSets - 1));
   // With a single way this is always true, so every NEXT advances the set.
   assign w_last_way = (r_way == WayW'(NumWays - 1));

   assign tag_set_o  = r_set;
   assign tag_way_o  = r_way;
   assign wb_count_o = r_wb_cnt;

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Line walker: way is the inner loop, set the outer loop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_set <= '0;
         r_way <= '0;
      end else if (r_state == S_DONE) begin
         r_set <= '0;
         r_way <= '0;
      end else if ((r_state == S_NEXT) && !(w_last_set && w_last_way)) begin
         if (w_last_way) begin
            r_way <= '0;
            r_set <= r_set + SetW'(1);
         end else begin
            r_way <= r_way + WayW'(1);
         end
      end
   end

   // Writeback statistics: cleared at flush start and held after completion
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wb_cnt <= '0;
      end else if ((r_state == S_IDLE) && flush_i) begin
         r_wb_cnt <= '0;
      end else if ((r_state == S_WB_REQ) && wb_gnt_i && (r_wb_cnt != '1)) begin
         r_wb_cnt <= r_wb_cnt + CntW'(1);
      end
   end

   // Next state and outputs
   always_comb begin
      w_state_nxt = r_state;
      busy_o      = 1'b1;
      flush_ack_o = 1'b0;
      tag_req_o   = 1'b0;
      wb_req_o    = 1'b0;
      upd_we_o    = 1'b0;
      upd_valid_o = 1'b0;
      upd_dirty_o = 1'b0;

      case (r_state)
         S_IDLE: begin
            busy_o = 1'b0;
            if (flush_i) begin
               w_state_nxt = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (miss_idle_i) begin
               w_state_nxt = S_READ;
            end
         end
         S_READ: begin
            tag_req_o = 1'b1;
            if (tag_gnt_i) begin
               w_state_nxt = S_CHECK;
            end
         end
         S_CHECK: begin
            if (rd_valid_i && rd_dirty_i) begin
               w_state_nxt = S_WB_REQ;
            end else if (rd_valid_i && InvalidateOnFlush) begin
               w_state_nxt = S_UPDATE;
            end else begin
               w_state_nxt = S_NEXT;
            end
         end
         S_WB_REQ: begin
            wb_req_o = 1'b1;
            if (wb_gnt_i) begin
               w_state_nxt = S_WB_WAIT;
            end
         end
         S_WB_WAIT: begin
            if (wb_done_i) begin
               w_state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: begin
            upd_we_o    = 1'b1;
            upd_valid_o = ~InvalidateOnFlush;
            upd_dirty_o = 1'b0;
            w_state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (w_last_set && w_last_way) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_DONE: begin
            flush_ack_o = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_flush_ctrl
//
// Three 4-set x 2-way instances:
//   0: InvalidateOnFlush=1, CntW=16
//   1: InvalidateOnFlush=0, CntW=16
//   2: InvalidateOnFlush=1, CntW=2
// Each instance has its own metadata image (mem_v/mem_d, bit index set*2+way).
// A responder returns the metadata the cycle after a grant. It accepts
// writebacks immediately and pulses wb_done 4 cycles after the grant.
// Expected handshake events are queued before each flush. A monitor pops
// and compares them whenever a DUT presents an event.
// ---------------------------------------------------------------------------
module tb_dcache_flush_ctrl;
   localparam int NI = 3;

   typedef struct {
      int inst;
      int kind;   // 0 tag read, 1 writeback, 2 update, 3 ack
      int s;
      int w;
      int v;      // update: valid bit; ack: wb_count
      int lat;    // ack only: cycles from flush sampled to ack, -1 = skip
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NI-1:0] flush, ack, busy, tag_req, tag_gnt, rd_v, rd_d;
   logic [NI-1:0] wb_req, wb_gnt, wb_done, upd_we, upd_v, upd_d;
   logic          miss_idle, gnt_en;
   logic [1:0]    tset [NI];
   logic          tway [NI];
   logic [15:0]   wbc  [NI];
   logic [7:0]    mem_v [NI];
   logic [7:0]    mem_d [NI];

   int unsigned cyc = 0;
   int unsigned flush_cyc = 0;
   int errors = 0;
   int checks = 0;
   ev_t expq[$];
   string knm [4] = '{"tag_read", "writeback", "update", "ack"};

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam bit          INV = (g != 1);
      localparam int unsigned CW  = (g == 2) ? 2 : 16;
      logic [CW-1:0] cnt_l;
      logic          rv_q = 1'b0;
      logic          rd_q = 1'b0;
      int unsigned   dcnt;

      dcache_flush_ctrl #(
         .NumSets(4),
         .NumWays(2),
         .InvalidateOnFlush(INV),
         .CntW(CW)
      ) u_dut (
         .clk_i      (clk),
         .rst_ni     (rst_n),
         .flush_i    (flush[g]),
         .flush_ack_o(ack[g]),
         .busy_o     (busy[g]),
         .miss_idle_i(miss_idle),
         .tag_req_o  (tag_req[g]),
         .tag_gnt_i  (tag_gnt[g]),
         .tag_set_o  (tset[g]),
         .tag_way_o  (tway[g]),
         .rd_valid_i (rd_v[g]),
         .rd_dirty_i (rd_d[g]),
         .wb_req_o   (wb_req[g]),
         .wb_gnt_i   (wb_gnt[g]),
         .wb_done_i  (wb_done[g]),
         .upd_we_o   (upd_we[g]),
         .upd_valid_o(upd_v[g]),
         .upd_dirty_o(upd_d[g]),
         .wb_count_o (cnt_l)
      );

      assign wbc[g]     = 16'(cnt_l);
      assign tag_gnt[g] = tag_req[g] & gnt_en;
      assign wb_gnt[g]  = wb_req[g];
      assign wb_done[g] = (dcnt == 1);
      assign rd_v[g]    = rv_q;
      assign rd_d[g]    = rd_q;

      always @(posedge clk) begin
         if (tag_req[g] && tag_gnt[g]) begin
            rv_q <= mem_v[g][{tset[g], tway[g]}];
            rd_q <= mem_d[g][{tset[g], tway[g]}];
         end
      end

      always @(posedge clk or negedge rst_n) begin
         if (!rst_n)                        dcnt <= 0;
         else if (wb_req[g] && wb_gnt[g])   dcnt <= 4;
         else if (dcnt != 0)                dcnt <= dcnt - 1;
      end
   end

   // Monitor: one event per instance per cycle (states are exclusive)
   always @(negedge clk) begin : mon
      ev_t e;
      int  k;
      int  lat;
      bit  ok;
      if (rst_n) begin
         for (int g = 0; g < NI; g++) begin
            k = -1;
            if (tag_req[g] && tag_gnt[g])     k = 0;
            else if (wb_req[g] && wb_gnt[g])  k = 1;
            else if (upd_we[g])               k = 2;
            else if (ack[g])                  k = 3;
            if (k >= 0) begin
               lat = int'(cyc - flush_cyc) + 1;
               checks++;
               if (expq.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_%s inst%0d: got set=%0d way=%0d, required no event",
                           knm[k], g, tset[g], tway[g]);
               end else begin
                  e  = expq.pop_front();
                  ok = (e.inst == g) && (e.kind == k);
                  if (ok && k != 3) ok = (e.s == int'(tset[g])) && (e.w == int'(tway[g]));
                  if (ok && k == 2) ok = (e.v == int'(upd_v[g])) && (upd_d[g] == 1'b0);
                  if (ok && k == 3) ok = (e.v == int'(wbc[g])) && (e.lat < 0 || e.lat == lat);
                  if (!ok) begin
                     errors++;
                     $display("FAIL %s inst%0d: got %s set=%0d way=%0d uv=%0d ud=%0d cnt=%0d lat=%0d, required %s inst%0d set=%0d way=%0d val=%0d lat=%0d",
                              knm[e.kind], g, knm[k], tset[g], tway[g], upd_v[g], upd_d[g],
                              wbc[g], lat, knm[e.kind], e.inst, e.s, e.w, e.v, e.lat);
                  end
               end
            end
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int g, input int k, input int s, input int w, input int v, input int lat);
      ev_t e;
      e = '{inst: g, kind: k, s: s, w: w, v: v, lat: lat};
      expq.push_back(e);
   endtask

   // Expected event list for one flush of instance g over its metadata image
   task automatic push_walk(input int g, input bit inv, input int cnt, input int lat);
      int i;
      for (int s = 0; s < 4; s++) begin
         for (int w = 0; w < 2; w++) begin
            i = s * 2 + w;
            push(g, 0, s, w, 0, 0);
            if (mem_v[g][i] && mem_d[g][i]) begin
               push(g, 1, s, w, 0, 0);
               push(g, 2, s, w, inv ? 0 : 1, 0);
            end else if (mem_v[g][i] && inv) begin
               push(g, 2, s, w, 0, 0);
            end
         end
      end
      push(g, 3, 0, 0, cnt, lat);
   endtask

   task automatic start_flush(input int g);
      @(posedge clk); #1 flush[g] = 1'b1;
      @(posedge clk); #1 flush_cyc = cyc;
   endtask

   task automatic finish_flush(input int g, input string nm);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack[g] && n < 3000);
      if (!ack[g]) begin
         checks++;
         errors++;
         $display("FAIL %s_ack_timeout: got no flush_ack in %0d cycles, required ack", nm, n);
      end
      @(posedge clk); #1 flush[g] = 1'b0;
      @(negedge clk);
      chk({nm, "_busy_after"}, int'(busy[g]), 0);
      chk({nm, "_set_after"}, int'(tset[g]), 0);
      chk({nm, "_way_after"}, int'(tway[g]), 0);
      chk({nm, "_events_left"}, expq.size(), 0);
      expq.delete();
   endtask

   task automatic chk_quiet(input int g, input string nm);
      chk({nm, "_busy"}, int'(busy[g]), 0);
      chk({nm, "_ack"}, int'(ack[g]), 0);
      chk({nm, "_tag_req"}, int'(tag_req[g]), 0);
      chk({nm, "_wb_req"}, int'(wb_req[g]), 0);
      chk({nm, "_upd_we"}, int'(upd_we[g]), 0);
      chk({nm, "_set"}, int'(tset[g]), 0);
      chk({nm, "_way"}, int'(tway[g]), 0);
      chk({nm, "_wb_count"}, int'(wbc[g]), 0);
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      flush     = '0;
      miss_idle = 1'b1;
      gnt_en    = 1'b1;
      for (int g = 0; g < NI; g++) begin
         mem_v[g] = '0;
         mem_d[g] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) chk_quiet(g, $sformatf("reset_i%0d", g));
      rst_n = 1'b1;

      // T1: all invalid, 1 + 3*8 + 1 = 26 cycles, no writeback or update
      push_walk(0, 1'b1, 0, 26);
      start_flush(0);
      finish_flush(0, "t1_invalid");

      // T2: all valid, (1,1) and (3,0) dirty, invalidate on flush
      // latency 1 + 6*4 + 2*(2+1+4+1+1) + 1 = 44
      mem_v[0] = 8'hFF;
      mem_d[0] = 8'b0100_1000;
      push_walk(0, 1'b1, 2, 44);
      start_flush(0);
      finish_flush(0, "t2_two_dirty");

      // T3: clean-only then all-dirty with InvalidateOnFlush=0
      mem_v[1] = 8'hFF;
      mem_d[1] = 8'h00;
      push_walk(1, 1'b0, 0, 26);
      start_flush(1);
      finish_flush(1, "t3_clean_keep");
      mem_d[1] = 8'hFF;
      push_walk(1, 1'b0, 8, 74);
      start_flush(1);
      finish_flush(1, "t3_dirty_keep");

      // T4: miss unit busy for 10 cycles, first read grant withheld 5 cycles
      mem_v[0] = '0;
      mem_d[0] = '0;
      push_walk(0, 1'b1, 0, -1);
      miss_idle = 1'b0;
      start_flush(0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk($sformatf("t4_no_req_c%0d", i), int'(tag_req[0]), 0);
      end
      gnt_en    = 1'b0;
      miss_idle = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!tag_req[0] && n < 20);
      chk("t4_req_rises", int'(tag_req[0]), 1);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t4_req_held_c%0d", i), int'(tag_req[0]), 1);
         chk($sformatf("t4_set_stable_c%0d", i), int'(tset[0]), 0);
         chk($sformatf("t4_way_stable_c%0d", i), int'(tway[0]), 0);
         @(negedge clk);
      end
      gnt_en = 1'b1;
      finish_flush(0, "t4_stall");

      // T5: reset asserted while a writeback is in flight
      mem_v[0] = 8'h02;
      mem_d[0] = 8'h02;
      push_walk(0, 1'b1, 1, -1);
      start_flush(0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!wb_req[0] && n < 50);
      chk("t5_wb_req_seen", int'(wb_req[0]), 1);
      @(negedge clk);
      #1 flush[0] = 1'b0;
      rst_n = 1'b0;
      #1 chk_quiet(0, "t5_async_reset");
      expq.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("t5_no_ack_after_reset", int'(busy[0]), 0);
      mem_v[0] = '0;
      mem_d[0] = '0;
      push_walk(0, 1'b1, 0, 26);
      start_flush(0);
      finish_flush(0, "t5_restart");

      // T6: five dirty lines on a 2-bit counter saturate at 3
      mem_v[2] = 8'hFF;
      mem_d[2] = 8'b1010_1101;
      push_walk(2, 1'b1, 3, -1);
      start_flush(2);
      finish_flush(2, "t6_saturate");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

endmodule
